tdot_serial: RTL

- Folded, time-multiplexed counterpart of the parallel three-term dot-product pipeline.
- Consumes one (a, b) operand pair per cycle over a valid/ready stream, together with the accumulator seed c on the first element.
- Emits y = c + sum(a_i*b_i), taken mod 2^WIDTH, over a valid/ready result port.
- Sits between a streaming operand source and the downstream consumer; uses one multiplier instead of LEN.

---
 rtl/tdot_serial_if.sv | 28 ++
 rtl/tdot_serial.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tdot_serial_if.sv
// Operand/result stream bundle for tdot_serial.
// Carries the (a, b, c) operand stream with in_valid/in_ready, the y result
// stream with out_valid/out_ready, and the busy status flag.
interface tdot_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  // master: operand source / result consumer side
  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, y, busy
  );

  // slave: the dot-product engine side
  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/tdot_serial.sv
// Folded dot product: y = c + sum(a_i*b_i) mod 2^WIDTH over LEN serial pairs.
// Ports: clk, reset (async, active-high), bus (tdot_serial_if.slave):
//   in_valid/in_ready/a/b/c operand stream, out_valid/out_ready/y result, busy.
// Latency: last pair accepted at edge E -> out_valid after edge E+3; y held
// until consumed, and no new vector is accepted until then.
module tdot_serial #(
  parameter int WIDTH = 8,
  parameter int LEN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  tdot_serial_if.slave  bus
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] y_q;

  // S1: operand registers
  logic             s1_vld, s1_first, s1_last;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c;
  // S2: product register
  logic             s2_vld, s2_first, s2_last;
  logic [WIDTH-1:0] s2_m, s2_c;
  // S3: accumulator; acc_done pulses the cycle the final product lands
  logic [WIDTH-1:0] acc;
  logic             acc_done;

  logic take;
  logic elem_first;
  logic elem_last;

  // in_ready_q is registered alongside state, so it is 1 exactly in IDLE/ACCUM.
  assign take       = bus.in_valid && in_ready_q;
  assign elem_first = (state == IDLE);
  assign elem_last  = (state == IDLE) ? (LEN == 1) : (idx == LAST_IDX);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.busy      = busy_q;

  // Three-stage datapath: operand regs, multiplier reg, accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_m     <= '0;
      s2_c     <= '0;
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      s1_vld <= take;
      if (take) begin
        s1_a     <= bus.a;
        s1_b     <= bus.b;
        s1_first <= elem_first;
        s1_last  <= elem_last;
        if (elem_first) s1_c <= bus.c;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_m     <= s1_a * s1_b;  // truncated to WIDTH by context
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_c     <= s1_c;
      end

      acc_done <= s2_vld && s2_last;
      if (s2_vld) begin
        acc <= s2_first ? (s2_c + s2_m) : (acc + s2_m);
      end
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            busy_q <= 1'b1;
            if (elem_last) begin
              state      <= DRAIN;
              idx        <= '0;
              in_ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (acc_done) begin
            state       <= RESULT;
            out_valid_q <= 1'b1;
            y_q         <= acc;
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          idx         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
